chacha_keystream_xor: RTL and testbench
=======================================

# chacha_keystream_xor

Downstream consumer of the ChaCha block state. Sweeps the 6-bit byte address across the four column-quarter holders, takes the OR-combined keystream byte they return, and XORs it with a plaintext byte stream under valid/ready handshake. Releases each 64-byte block back to the core when it is exhausted or when the message ends, so the core can compute the next block.

## Interface
Parameters:
- `BLOCK_BYTES`, 64, keystream bytes per block; fixed at 64, matching the 6-bit address.

Ports:
- `clk` input 1: clock.
- `rst_n` input 1: reset, synchronous, active-low.
- `blk_valid` input 1: core asserts (level) when a finished keystream block is held in the quarters.
- `blk_done` output 1: one-cycle pulse; this block is finished with the held keystream.
- `ks_addr` output 6: byte address to the quarters; [5:4] row, [3:2] column, [1:0] byte.
- `ks_data` input 8: OR of all quarter outputs; combinational from `ks_addr`.
- `in_valid` input 1: plaintext byte valid.
- `in_ready` output 1: plaintext byte accepted when `in_valid && in_ready`.
- `in_data` input 8: plaintext byte.
- `in_last` input 1: final byte of message; qualified by `in_valid`.
- `out_valid` output 1: ciphertext byte valid.
- `out_ready` input 1: downstream accepts when `out_valid && out_ready`.
- `out_data` output 8: ciphertext byte.
- `out_last` output 1: final byte of message; qualified by `out_valid`.

## Operation
- States: WAIT_BLK, STREAM, RELEASE.
- WAIT_BLK: `ks_addr`=0 and `in_ready`=0. If `blk_valid`, go to STREAM.
- STREAM: `in_ready` = `!out_valid || out_ready`; it is never asserted outside STREAM. On accept:
  - `out_data` <= `in_data ^ ks_data`, `out_last` <= `in_last`, `out_valid` <= 1.
  - `ks_addr` <= `ks_addr + 1` (6-bit wrap).
  - If `ks_addr == 63` or `in_last`, go to RELEASE.
- RELEASE: `blk_done`=1 for exactly this cycle and `in_ready`=0. Next state is WAIT_BLK, with `ks_addr` <= 0.
- After `in_last`, the unused keystream is discarded. The next message starts on a fresh block at address 0.
- Output register:
  - `out_valid` clears on `out_ready` unless a new accept happens in the same cycle; on simultaneous drain and accept it stays 1 with the new data.
  - `out_data` and `out_last` hold while `out_valid && !out_ready`.
- Address 63 combined with `in_last` produces a single RELEASE. There is never a double `blk_done`.
- Core contract: the core samples `blk_done` and deasserts `blk_valid` at the same edge. The held state must remain stable from `blk_valid` rising until that edge.
- RELEASE does not wait for the output register to drain. The last byte may still be pending in WAIT_BLK.

## Timing
- Reset values: `ks_addr`=0, `blk_done`=0, `in_ready`=0, `out_valid`=0, `out_data`=0, `out_last`=0, state=WAIT_BLK. Reset mid-operation drops any pending output byte.
- `blk_valid` high at cycle t means state is STREAM and `in_ready` can be 1 at t+1.
- An accept at cycle t makes `out_valid`/`out_data` visible at t+1. Latency is 1 cycle.
- `ks_addr` is registered. `ks_data` must settle within the same cycle as `ks_addr`.
- Sustained throughput: 1 byte/cycle while `out_ready`=1. Block overhead: RELEASE plus WAIT_BLK is 2 cycles minimum, plus the core's compute time.
- `blk_done` is registered-state decoded and glitch-free.

## Structure
- Shared package/header `chacha_pkg`: state encoding (WAIT_BLK=0, STREAM=1, RELEASE=2), `BLOCK_BYTES`=64, and address field slices (ROW/COL/BYTE bit positions) shared with the quarter holders.
- Single module; no sub-module. The output register is inline.

## Test plan
- Reset, then `blk_valid`=1 with all-zero keystream; stream 64 bytes 0x00..0x3F with `out_ready`=1:
  - `out_data` equals the input;
  - `ks_addr` steps 0..63;
  - `blk_done` pulses one cycle after the 64th accept.
- Keystream byte at address k = k^0xA5; plaintext 0xFF ×64 -> `out_data` = 0x5A^k for each k, in order.
- `in_last` on byte 10 -> `out_last`=1 on output byte 10 and `blk_done` pulses. On the next block, `ks_addr` restarts at 0 and the first `out_data` uses address 0.
- `out_ready` low for 5 cycles mid-block -> `in_ready`=0 from the second cycle, `out_data` stable, no byte lost or duplicated. Apply `out_ready` and an accept in the same cycle -> continuous `out_valid`.
- `in_last` on byte 63 -> exactly one `blk_done` pulse and `out_last`=1.
- Pull `rst_n` low mid-block with `out_valid`=1 -> next cycle all outputs are at reset values. The stream resumes from `ks_addr` 0 after `blk_valid`.

Source files
------------

// File: rtl/chacha_pkg.sv
// Shared definitions for the ChaCha keystream consumer and the quarter holders:
// controller state encoding, block size and the byte-address field layout.
package chacha_pkg;

  localparam int BLOCK_BYTES = 64;
  localparam int ADDR_W      = 6;

  // Controller state encoding.
  localparam logic [1:0] ST_WAIT_BLK = 2'd0;
  localparam logic [1:0] ST_STREAM   = 2'd1;
  localparam logic [1:0] ST_RELEASE  = 2'd2;

  // Byte address layout: [5:4] row, [3:2] column, [1:0] byte within the word.
  localparam int ROW_MSB  = 5;
  localparam int ROW_LSB  = 4;
  localparam int COL_MSB  = 3;
  localparam int COL_LSB  = 2;
  localparam int BYTE_MSB = 1;
  localparam int BYTE_LSB = 0;

  function automatic logic [1:0] addr_row(input logic [ADDR_W-1:0] addr);
    return addr[ROW_MSB:ROW_LSB];
  endfunction

  function automatic logic [1:0] addr_col(input logic [ADDR_W-1:0] addr);
    return addr[COL_MSB:COL_LSB];
  endfunction

  function automatic logic [1:0] addr_byte(input logic [ADDR_W-1:0] addr);
    return addr[BYTE_MSB:BYTE_LSB];
  endfunction

endpackage

// File: rtl/chacha_keystream_xor.sv
// Walks the 64 keystream bytes of a held ChaCha block, XORs them onto a
// plaintext byte stream and hands the block back to the core when it is used
// up or the message ends.
//
// Handshake: a byte moves on an interface exactly on a clock edge where both
// its valid and ready are high. in_ready never depends on in_valid;
// out_valid/out_data/out_last hold steady while out_valid && !out_ready.
module chacha_keystream_xor
  import chacha_pkg::ADDR_W;
  import chacha_pkg::ST_WAIT_BLK;
  import chacha_pkg::ST_STREAM;
  import chacha_pkg::ST_RELEASE;
#(
  parameter int BLOCK_BYTES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              blk_valid,
  output logic              blk_done,
  output logic [ADDR_W-1:0] ks_addr,
  input  logic [7:0]        ks_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_last,
  output logic [1:0]        state_dbg
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BLOCK_BYTES - 1);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       accept;
  logic       end_of_block;

  // Plaintext is only taken while streaming and when the output slot is free
  // or being drained this cycle.
  assign in_ready     = (state == ST_STREAM) && (!out_valid || out_ready);
  assign accept       = in_valid && in_ready;
  assign end_of_block = (ks_addr == LAST_ADDR) || in_last;

  // Decoded from registered state only, so the pulse is glitch-free.
  assign blk_done  = (state == ST_RELEASE);
  assign state_dbg = state;

  // Next-state logic: wait for a block, stream it, release it for one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_WAIT_BLK: if (blk_valid) state_nxt = ST_STREAM;
      ST_STREAM:   if (accept && end_of_block) state_nxt = ST_RELEASE;
      ST_RELEASE:  state_nxt = ST_WAIT_BLK;
      default:     state_nxt = ST_WAIT_BLK;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_WAIT_BLK;
    end else begin
      state <= state_nxt;
    end
  end

  // Keystream byte address: advances per accepted byte, rewinds on release so
  // every message starts at byte 0 of a fresh block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ks_addr <= '0;
    end else if (state == ST_RELEASE) begin
      ks_addr <= '0;
    end else if (accept) begin
      ks_addr <= ks_addr + ADDR_W'(1);
    end
  end

  // Output register: loads on accept, empties on drain, holds while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_last  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= in_data ^ ks_data;
      out_last  <= in_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_chacha_keystream_xor.sv
// Bench for chacha_keystream_xor: a behavioural ChaCha core supplies keystream
// blocks, driver tasks push plaintext, and a scoreboard compares the ciphertext
// against a model that tracks message/block position directly.
module tb_chacha_keystream_xor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       blk_valid;
  logic       blk_done;
  logic [5:0] ks_addr;
  logic [7:0] ks_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] exp_q[$];
  logic [8:0] exp_e;

  int   ks_mode  = 0;
  int   blk_cnt  = 0;
  int   core_gap = 2;
  logic or_rand  = 1'b0;
  logic or_force = 1'b1;

  int   m_pos    = 0;
  int   m_blk    = 0;
  int   m_done   = 0;
  int   obs_done = 0;
  logic prev_done = 1'b0;

  chacha_keystream_xor #(.BLOCK_BYTES(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .blk_valid (blk_valid),
    .blk_done  (blk_done),
    .ks_addr   (ks_addr),
    .ks_data   (ks_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Keystream content of block number blk at byte address a.
  function automatic logic [7:0] ks_fn(input int mode, input int blk, input logic [5:0] a);
    case (mode)
      0:       return 8'h00;
      1:       return {2'b00, a} ^ 8'hA5;
      default: return 8'((blk * 37 + int'(a) * 11 + 60) ^ (blk * 7));
    endcase
  endfunction

  // Quarter holders: combinational read of the held block.
  assign ks_data = ks_fn(ks_mode, blk_cnt, ks_addr);

  // Core model: holds blk_valid until it sees blk_done, then computes the next
  // block for a few cycles.
  initial begin
    blk_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        blk_valid = 1'b0;
        core_gap  = 2;
      end else if (blk_done) begin
        blk_valid = 1'b0;
        blk_cnt   = blk_cnt + 1;
        core_gap  = $urandom_range(0, 3);
      end else if (!blk_valid) begin
        if (core_gap == 0) blk_valid = 1'b1;
        else core_gap = core_gap - 1;
      end
    end
  end

  // Downstream sink: fixed or random backpressure.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = or_rand ? 1'($urandom_range(0, 1)) : or_force;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (out_valid && out_ready) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL out_unexpected: got %02h last=%0d, expected nothing", out_data, out_last);
          end else begin
            exp_e = exp_q.pop_front();
            if ({out_last, out_data} !== exp_e) begin
              n_fail++;
              $display("FAIL out_byte: got last=%0d data=%02h, expected last=%0d data=%02h",
                       out_last, out_data, exp_e[8], exp_e[7:0]);
            end
          end
        end
        if (blk_done) begin
          obs_done++;
          n_checks++;
          if (prev_done) begin
            n_fail++;
            $display("FAIL blk_done_double: blk_done high on two consecutive cycles, expected single pulse");
          end
        end
        prev_done = blk_done;
      end else begin
        prev_done = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Present one plaintext byte, wait for it to be taken, log expectations.
  task automatic send_byte(input logic [7:0] d, input logic l);
    int   t;
    logic rel;
    logic [7:0] key;
    t        = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 300) begin
        n_checks++;
        n_fail++;
        $display("FAIL in_ready_timeout: in_ready=0 for %0d cycles, expected 1", t);
        in_valid = 1'b0;
        return;
      end
    end
    n_checks++;
    if (ks_addr !== 6'(m_pos)) begin
      n_fail++;
      $display("FAIL ks_addr: got %0d, expected %0d", ks_addr, m_pos);
    end
    key = ks_fn(ks_mode, m_blk, 6'(m_pos));
    exp_q.push_back({l, d ^ key});
    rel = (m_pos == 63) || l;
    if (rel) begin
      m_pos  = 0;
      m_blk  = m_blk + 1;
      m_done = m_done + 1;
    end else begin
      m_pos = m_pos + 1;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    n_checks++;
    if (blk_done !== rel) begin
      n_fail++;
      $display("FAIL blk_done: got %0d after accept, expected %0d", blk_done, rel);
    end
  endtask

  task automatic drain();
    int t;
    t        = 0;
    or_rand  = 1'b0;
    or_force = 1'b1;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d bytes still pending, expected 0", exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({ks_addr, blk_done, in_ready, out_valid, out_data, out_last, state_dbg} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_values: addr=%0d done=%0d rdy=%0d ov=%0d od=%02h ol=%0d st=%0d, expected all 0",
               ks_addr, blk_done, in_ready, out_valid, out_data, out_last, state_dbg);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0 || blk_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_blk_ready: in_ready=%0d blk_valid=%0d, expected 0 0", in_ready, blk_valid);
    end
  endtask

  task automatic test_zero_ks();
    ks_mode = 0;
    for (int i = 0; i < 64; i++) send_byte(8'(i), 1'b0);
    drain();
  endtask

  task automatic test_a5_ks();
    ks_mode = 1;
    for (int i = 0; i < 64; i++) send_byte(8'hFF, 1'b0);
    drain();
  endtask

  task automatic test_last10();
    ks_mode = 2;
    for (int i = 0; i < 11; i++) send_byte(8'($urandom), i == 10);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), i == 4);
    drain();
  endtask

  task automatic test_last63();
    int d0;
    ks_mode = 2;
    d0 = obs_done;
    for (int i = 0; i < 64; i++) send_byte(8'($urandom), i == 63);
    drain();
    n_checks++;
    if (obs_done - d0 !== 1) begin
      n_fail++;
      $display("FAIL last63_done_count: got %0d pulses, expected 1", obs_done - d0);
    end
  endtask

  task automatic test_stall();
    ks_mode  = 2;
    or_force = 1'b1;
    fork
      begin
        for (int i = 0; i < 24; i++) send_byte(8'($urandom), i == 23);
      end
      begin
        int t;
        logic [7:0] d0;
        t  = 0;
        d0 = 8'h00;
        while (!out_valid && t < 300) begin
          @(negedge clk);
          t++;
        end
        @(posedge clk);
        or_force = 1'b0;
        for (int c = 1; c <= 5; c++) begin
          @(negedge clk);
          if (c == 1) begin
            d0 = out_data;
          end else begin
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== d0) begin
              n_fail++;
              $display("FAIL stall_hold: rdy=%0d ov=%0d od=%02h, expected 0 1 %02h",
                       in_ready, out_valid, out_data, d0);
            end
          end
        end
        @(posedge clk);
        or_force = 1'b1;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          n_checks++;
          if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stream_continuous: out_valid=%0d, expected 1", out_valid);
          end
        end
      end
    join
    drain();
  endtask

  task automatic test_random();
    int len;
    ks_mode = 2;
    or_rand = 1'b1;
    for (int m = 0; m < 6; m++) begin
      len = $urandom_range(1, 140);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
        send_byte(8'($urandom), i == len - 1);
      end
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int t;
    ks_mode  = 2;
    or_rand  = 1'b0;
    or_force = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    t        = 0;
    in_valid = 1'b1;
    in_data  = 8'($urandom);
    in_last  = 1'b0;
    while (t < 300) begin
      @(negedge clk);
      if (in_ready) break;
      t++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_pending: out_valid=%0d, expected 1", out_valid);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if ({ks_addr, blk_done, in_ready, out_valid, out_data, out_last} !== 18'h0) begin
      n_fail++;
      $display("FAIL mid_reset_values: addr=%0d done=%0d rdy=%0d ov=%0d od=%02h ol=%0d, expected all 0",
               ks_addr, blk_done, in_ready, out_valid, out_data, out_last);
    end
    rst_n    = 1'b1;
    or_force = 1'b1;
    m_pos    = 0;
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), i == 7);
    drain();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_zero_ks();
    test_a5_ks();
    test_last10();
    test_stall();
    test_last63();
    test_random();
    test_reset_mid();
    n_checks++;
    if (obs_done !== m_done) begin
      n_fail++;
      $display("FAIL done_total: got %0d blk_done pulses, expected %0d", obs_done, m_done);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
